// File: rtl/hazard_control_unit.sv
// -----------------------------------------------------------------------------
// hazard_control_unit
//
// Pipeline hazard controller for a five-stage in-order core. It resolves three
// kinds of hazard, in this priority order:
//   1. data-memory wait (mem_req && !mem_ready): the whole front of the pipe is
//      frozen until the MEM-stage access completes,
//   2. branch/jump mispredict resolved in EX: the wrong-path IF/ID and ID/EX
//      contents are squashed for two cycles (the cycle the mispredict is seen and
//      the REDIRECT cycle that follows it),
//   3. load-use: the ID instruction is held for one cycle and a bubble is
//      injected into ID/EX.
// Control outputs are combinational from the current state and inputs. State,
// performance counters and the sticky timeout flag are registered.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   id_rs1, id_rs2               ID-stage source registers
//   id_uses_rs1, id_uses_rs2     ID instruction really reads that source
//   ex_wb_load, ex_wb_rd         EX instruction is a load / its destination
//   ex_forward_pipeline_flush    EX holds a flush bubble
//   ex_mispredict                EX branch outcome disagrees with prediction
//   mem_req, mem_ready           MEM access outstanding / memory acknowledge
//   pc_en, if_id_en, if_id_flush PC and IF/ID controls
//   id_ex_en, id_ex_flush        ID/EX controls
//   ex_mem_en                    EX/MEM enable
//   stall_count, flush_count     saturating 16-bit performance counters
//   mem_timeout_err              sticky: 255 consecutive MEM_WAIT cycles seen
//   state                        current FSM state (debug)
// -----------------------------------------------------------------------------
module hazard_control_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        ex_wb_load,
    input  logic [4:0]  ex_wb_rd,
    input  logic        ex_forward_pipeline_flush,
    input  logic        ex_mispredict,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        if_id_flush,
    output logic        id_ex_en,
    output logic        id_ex_flush,
    output logic        ex_mem_en,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count,
    output logic        mem_timeout_err,
    output logic [1:0]  state
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_REDIRECT = 2'd2;

    // Saturating increment helpers for the counters.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            sat_inc16 = v;
        end else begin
            sat_inc16 = v + 16'd1;
        end
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            sat_inc8 = v;
        end else begin
            sat_inc8 = v + 8'd1;
        end
    endfunction

    logic [1:0]  state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        err_q, err_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    logic mem_stall_s;
    logic load_use_s;
    logic mispredict_s;
    logic act_mispredict_s;
    logic act_load_use_s;

    assign mem_stall_s  = mem_req && !mem_ready;
    assign load_use_s   = ex_wb_load && (ex_wb_rd != 5'd0) &&
                          ((id_uses_rs1 && (id_rs1 == ex_wb_rd)) ||
                           (id_uses_rs2 && (id_rs2 == ex_wb_rd)));
    // A bubble in EX carries no real branch outcome, so it never redirects.
    assign mispredict_s = ex_mispredict && !ex_forward_pipeline_flush;

    // Decide which lower-priority event is actually acted on this cycle.
    // REDIRECT ignores both: the EX/ID contents are already being squashed.
    always_comb begin
        act_mispredict_s = 1'b0;
        act_load_use_s   = 1'b0;
        if (mem_stall_s) begin
            act_mispredict_s = 1'b0;
            act_load_use_s   = 1'b0;
        end else if ((state_q == ST_RUN) || (state_q == ST_MEM_WAIT)) begin
            if (mispredict_s) begin
                act_mispredict_s = 1'b1;
            end else if (load_use_s) begin
                act_load_use_s = 1'b1;
            end else begin
                act_mispredict_s = 1'b0;
                act_load_use_s   = 1'b0;
            end
        end else begin
            act_mispredict_s = 1'b0;
            act_load_use_s   = 1'b0;
        end
    end

    // State, counter and sticky-flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= 8'd0;
            err_q       <= 1'b0;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = ST_RUN;
        case (state_q)
            ST_RUN, ST_MEM_WAIT: begin
                if (mem_stall_s) begin
                    state_d = ST_MEM_WAIT;
                end else if (act_mispredict_s) begin
                    state_d = ST_REDIRECT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_REDIRECT: begin
                if (mem_stall_s) begin
                    state_d = ST_MEM_WAIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            // Unused encoding recovers to RUN unconditionally.
            default: state_d = ST_RUN;
        endcase
    end

    // Counter and timeout next values.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (mem_stall_s || act_load_use_s) begin
            stall_cnt_d = sat_inc16(stall_cnt_q);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (act_mispredict_s) begin
            flush_cnt_d = sat_inc16(flush_cnt_q);
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
        // Wait counter holds the number of consecutive MEM_WAIT cycles,
        // including the one being entered, and clears on leaving.
        if (state_d == ST_MEM_WAIT) begin
            wait_cnt_d = sat_inc8(wait_cnt_q);
        end else begin
            wait_cnt_d = 8'd0;
        end
        err_d = err_q || (wait_cnt_d == 8'hFF);
    end

    // Control outputs from current state and inputs.
    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b0;
        ex_mem_en   = 1'b1;
        if (rst) begin
            // Present the idle RUN pattern while held in reset.
            pc_en       = 1'b1;
            if_id_en    = 1'b1;
            if_id_flush = 1'b0;
            id_ex_en    = 1'b1;
            id_ex_flush = 1'b0;
            ex_mem_en   = 1'b1;
        end else if (mem_stall_s) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            if_id_flush = 1'b0;
            id_ex_en    = 1'b0;
            id_ex_flush = 1'b0;
            ex_mem_en   = 1'b0;
        end else begin
            case (state_q)
                ST_RUN, ST_MEM_WAIT: begin
                    if (act_mispredict_s) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (act_load_use_s) begin
                        // Hold PC and ID, inject one bubble into EX.
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                    end else begin
                        if_id_flush = 1'b0;
                        id_ex_flush = 1'b0;
                    end
                end
                ST_REDIRECT: begin
                    // Squash the wrong-path fetch issued during the redirect.
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end
                default: begin
                    if_id_flush = 1'b0;
                    id_ex_flush = 1'b0;
                end
            endcase
        end
    end

    assign stall_count     = stall_cnt_q;
    assign flush_count     = flush_cnt_q;
    assign mem_timeout_err = err_q;
    assign state           = state_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_control_unit
// Table-driven directed bench for hazard_control_unit, plus hand sequences for
// memory wait with pending mispredict, timeout, saturation and async reset.
// -----------------------------------------------------------------------------
module tb_hazard_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_wb_rd;
    logic        id_uses_rs1, id_uses_rs2, ex_wb_load;
    logic        ex_forward_pipeline_flush, ex_mispredict, mem_req, mem_ready;
    logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en;
    logic [15:0] stall_count, flush_count;
    logic        mem_timeout_err;
    logic [1:0]  state;

    int tests = 0;
    int fails = 0;

    hazard_control_unit dut (
        .clk                       (clk),
        .rst                       (rst),
        .id_rs1                    (id_rs1),
        .id_rs2                    (id_rs2),
        .id_uses_rs1               (id_uses_rs1),
        .id_uses_rs2               (id_uses_rs2),
        .ex_wb_load                (ex_wb_load),
        .ex_wb_rd                  (ex_wb_rd),
        .ex_forward_pipeline_flush (ex_forward_pipeline_flush),
        .ex_mispredict             (ex_mispredict),
        .mem_req                   (mem_req),
        .mem_ready                 (mem_ready),
        .pc_en                     (pc_en),
        .if_id_en                  (if_id_en),
        .if_id_flush               (if_id_flush),
        .id_ex_en                  (id_ex_en),
        .id_ex_flush               (id_ex_flush),
        .ex_mem_en                 (ex_mem_en),
        .stall_count               (stall_count),
        .flush_count               (flush_count),
        .mem_timeout_err           (mem_timeout_err),
        .state                     (state)
    );

    always #5 clk = ~clk;

    // Control pattern {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en}
    localparam logic [5:0] C_IDLE   = 6'b110101;
    localparam logic [5:0] C_LU     = 6'b000111;
    localparam logic [5:0] C_FLUSH  = 6'b111111;
    localparam logic [5:0] C_FREEZE = 6'b000000;

    typedef struct {
        string      name;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       ld;
        logic [4:0] rd;
        logic       bub;
        logic       mp;
        logic       req;
        logic       rdy;
        logic [5:0] exp_ctl;
        logic [1:0] exp_st;
        logic [15:0] exp_stall;
        logic [15:0] exp_flush;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(string nm, logic [4:0] rs1, logic [4:0] rs2,
                                logic u1, logic u2, logic ld, logic [4:0] rd,
                                logic bub, logic mp, logic req, logic rdy,
                                logic [5:0] ctl, logic [1:0] st,
                                logic [15:0] sc, logic [15:0] fc);
        vec_t v;
        v.name = nm; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
        v.ld = ld; v.rd = rd; v.bub = bub; v.mp = mp; v.req = req; v.rdy = rdy;
        v.exp_ctl = ctl; v.exp_st = st; v.exp_stall = sc; v.exp_flush = fc;
        return v;
    endfunction

    function automatic logic [5:0] ctl_now();
        return {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
        ex_wb_load = v.ld; ex_wb_rd = v.rd; ex_forward_pipeline_flush = v.bub;
        ex_mispredict = v.mp; mem_req = v.req; mem_ready = v.rdy;
    endtask

    task automatic idle_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_wb_load = 1'b0; ex_wb_rd = 5'd0; ex_forward_pipeline_flush = 1'b0;
        ex_mispredict = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        //                name        rs1   rs2   u1 u2 ld rd    bub mp req rdy ctl       st  stall  flush
        vecs[0]  = mk("idle",        5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, C_IDLE,   2'd0, 16'd0, 16'd0);
        vecs[1]  = mk("lu_rs1",      5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 0, 0, 0, C_LU,     2'd0, 16'd1, 16'd0);
        vecs[2]  = mk("lu_rd0",      5'd0, 5'd0, 1, 0, 1, 5'd0, 0, 0, 0, 0, C_IDLE,   2'd0, 16'd1, 16'd0);
        vecs[3]  = mk("lu_rs2",      5'd1, 5'd7, 0, 1, 1, 5'd7, 0, 0, 0, 0, C_LU,     2'd0, 16'd2, 16'd0);
        vecs[4]  = mk("lu_unused",   5'd9, 5'd0, 0, 0, 1, 5'd9, 0, 0, 0, 0, C_IDLE,   2'd0, 16'd2, 16'd0);
        vecs[5]  = mk("mispredict",  5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 0, C_FLUSH,  2'd2, 16'd2, 16'd1);
        vecs[6]  = mk("redir_lu",    5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 0, 0, 0, C_FLUSH,  2'd0, 16'd2, 16'd1);
        vecs[7]  = mk("mp_bubble",   5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 1, 0, 0, C_IDLE,   2'd0, 16'd2, 16'd1);
        vecs[8]  = mk("mstall_mp1",  5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1, 0, C_FREEZE, 2'd1, 16'd3, 16'd1);
        vecs[9]  = mk("mstall_mp2",  5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1, 0, C_FREEZE, 2'd1, 16'd4, 16'd1);
        vecs[10] = mk("mwait_mp",    5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1, 1, C_FLUSH,  2'd2, 16'd4, 16'd2);
        vecs[11] = mk("redir_idle",  5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, C_FLUSH,  2'd0, 16'd4, 16'd2);
        vecs[12] = mk("req_ready",   5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 1, C_IDLE,   2'd0, 16'd4, 16'd2);
        vecs[13] = mk("mstall_lu",   5'd3, 5'd0, 1, 0, 1, 5'd3, 0, 0, 1, 0, C_FREEZE, 2'd1, 16'd5, 16'd2);
        vecs[14] = mk("mwait_lu",    5'd3, 5'd0, 1, 0, 1, 5'd3, 0, 0, 0, 0, C_LU,     2'd0, 16'd6, 16'd2);

        idle_inputs();
        rst = 1'b1;
        #2;
        chk("rst_ctl", {26'd0, ctl_now()}, {26'd0, C_IDLE});
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_stall", {16'd0, stall_count}, 32'd0);
        chk("rst_flush", {16'd0, flush_count}, 32'd0);
        chk("rst_err", {31'd0, mem_timeout_err}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Table: comb outputs mid-cycle, registered results after the edge.
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i]);
            #3;
            chk({vecs[i].name, "_ctl"}, {26'd0, ctl_now()}, {26'd0, vecs[i].exp_ctl});
            @(posedge clk);
            #1;
            chk({vecs[i].name, "_state"}, {30'd0, state}, {30'd0, vecs[i].exp_st});
            chk({vecs[i].name, "_stall"}, {16'd0, stall_count}, {16'd0, vecs[i].exp_stall});
            chk({vecs[i].name, "_flush"}, {16'd0, flush_count}, {16'd0, vecs[i].exp_flush});
        end
        chk("table_err", {31'd0, mem_timeout_err}, 32'd0);

        // Memory wait with a mispredict held for three cycles, then released.
        idle_inputs();
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0; ex_mispredict = 1'b1;
        #3;
        chk("mw3_ctl", {26'd0, ctl_now()}, {26'd0, C_FREEZE});
        repeat (3) @(posedge clk);
        #1;
        chk("mw3_state", {30'd0, state}, 32'd1);
        chk("mw3_stall", {16'd0, stall_count}, 32'd3);
        chk("mw3_flush", {16'd0, flush_count}, 32'd0);
        mem_ready = 1'b1;
        #3;
        chk("mw3_rel_ctl", {26'd0, ctl_now()}, {26'd0, C_FLUSH});
        @(posedge clk);
        #1;
        chk("mw3_rel_state", {30'd0, state}, 32'd2);
        chk("mw3_rel_flush", {16'd0, flush_count}, 32'd1);
        chk("mw3_rel_stall", {16'd0, stall_count}, 32'd3);

        // Timeout: 300 stalled cycles, flag sets at wait count 255.
        idle_inputs();
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            if (c == 199) begin
                #1;
                chk("to_err_early", {31'd0, mem_timeout_err}, 32'd0);
            end
        end
        #1;
        chk("to_err", {31'd0, mem_timeout_err}, 32'd1);
        chk("to_stall", {16'd0, stall_count}, 32'd300);
        mem_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("to_err_sticky", {31'd0, mem_timeout_err}, 32'd1);
        chk("to_state_run", {30'd0, state}, 32'd0);

        // Asynchronous reset in the middle of MEM_WAIT, no clock edge needed.
        mem_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("arst_pre_state", {30'd0, state}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_state", {30'd0, state}, 32'd0);
        chk("arst_stall", {16'd0, stall_count}, 32'd0);
        chk("arst_flush", {16'd0, flush_count}, 32'd0);
        chk("arst_err", {31'd0, mem_timeout_err}, 32'd0);
        chk("arst_ctl", {26'd0, ctl_now()}, {26'd0, C_IDLE});
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Saturation: 70000 load-use cycles.
        idle_inputs();
        do_reset();
        ex_wb_load = 1'b1; ex_wb_rd = 5'd4; id_rs1 = 5'd4; id_uses_rs1 = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        chk("sat_stall", {16'd0, stall_count}, 32'h0000FFFF);
        chk("sat_state", {30'd0, state}, 32'd0);
        chk("sat_flush", {16'd0, flush_count}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
REQ-005 id_uses_rs1, id_uses_rs2  in  1 each  the ID instruction actually reads that source.
REQ-006 ex_wb_load  in  1  the instruction in EX is a load.
REQ-007 ex_wb_rd  in  5  destination register of the instruction in EX.
REQ-008 ex_forward_pipeline_flush  in  1  EX currently holds a flush bubble.
REQ-009 ex_mispredict  in  1  branch/jump resolved in EX disagrees with its prediction.
REQ-010 mem_req, mem_ready  in  1 each  MEM-stage data access outstanding / data memory acknowledge.
REQ-011 pc_en, if_id_en, if_id_flush  out  1 each  PC and IF/ID register controls.
REQ-012 id_ex_en, id_ex_flush  out  1 each  drive pipeline_en and pipeline_flush of the ID/EX register.
REQ-013 ex_mem_en  out  1  EX/MEM register enable.
REQ-014 stall_count, flush_count  out  16 each  performance counters.
REQ-015 mem_timeout_err  out  1  sticky data-memory timeout flag.
REQ-016 state  out  2  current FSM state, exposed for debug.

Function
REQ-017 The FSM SHALL have three states: RUN=0, MEM_WAIT=1, REDIRECT=2; encoding 3 SHALL return to RUN on the next clock.
REQ-018 Control outputs SHALL be combinational from state and current inputs; state and counters SHALL update on the rising edge of clk.
REQ-019 The block SHALL define mem_stall = mem_req && !mem_ready.
REQ-020 The block SHALL define load_use = ex_wb_load && ex_wb_rd!=0 && ((id_uses_rs1 && id_rs1==ex_wb_rd) || (id_uses_rs2 && id_rs2==ex_wb_rd)).
REQ-021 The block SHALL define mispredict = ex_mispredict && !ex_forward_pipeline_flush, so that bubbles never redirect.
REQ-022 Priority SHALL be mem_stall > mispredict > load_use.
REQ-023 Default, RUN with no event: all enables SHALL be 1 and both flushes SHALL be 0.
REQ-024 When mem_stall is true in any state: pc_en, if_id_en, id_ex_en and ex_mem_en SHALL be 0, both flushes SHALL be 0, and the next state SHALL be MEM_WAIT.
REQ-025 In MEM_WAIT, when mem_stall is false, outputs SHALL be as in RUN evaluated on the current inputs, and the next state SHALL follow the RUN rules.
REQ-026 On mispredict (no mem_stall): pc_en=1, if_id_flush=1, id_ex_flush=1, ex_mem_en=1, and the next state SHALL be REDIRECT.
REQ-027 In REDIRECT (no mem_stall): if_id_flush=1, id_ex_flush=1, all enables 1, to squash the wrong-path fetch issued during redirect; next state RUN.
REQ-028 load_use arising in REDIRECT SHALL be ignored.
REQ-029 On load_use in RUN (no mem_stall, no mispredict): pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1, for exactly one cycle; next state RUN.
REQ-030 stall_count SHALL increment on each cycle with mem_stall or load_use acted on, and SHALL saturate at 16'hFFFF.
REQ-031 flush_count SHALL increment once per mispredict acted on (the cycle REQ-026 applies), and SHALL saturate at 16'hFFFF.
REQ-032 A mispredict held during mem_stall SHALL NOT be counted until acted on.
REQ-033 An 8-bit wait counter SHALL count consecutive MEM_WAIT cycles and clear whenever the state leaves MEM_WAIT.
REQ-034 When the wait counter reaches 255, mem_timeout_err SHALL set and remain set until rst.

Reset
REQ-035 On rst, the block SHALL force state=RUN, stall_count=0, flush_count=0, wait counter=0 and mem_timeout_err=0, asynchronously, including mid-MEM_WAIT or mid-REDIRECT.
REQ-036 While rst is asserted, outputs SHALL read as in RUN with all inputs idle: all enables 1 and both flushes 0.

Verification
REQ-037 Load-use: ex_wb_load=1, ex_wb_rd=5, id_rs1=5, id_uses_rs1=1 -> one cycle of pc_en=0, if_id_en=0, id_ex_flush=1; stall_count=1; repeat with ex_wb_rd=0 -> no stall.
REQ-038 Mispredict: ex_mispredict=1 for one cycle -> flushes asserted that cycle and the next (REDIRECT), state 0->2->0, flush_count=1; with ex_forward_pipeline_flush=1 -> no flush.
REQ-039 Memory wait with simultaneous mispredict: mem_req=1, mem_ready=0 for 3 cycles with ex_mispredict=1 -> all enables 0, state=1, stall_count=3, flush_count=0; then mem_ready=1 -> redirect, flush_count=1.
REQ-040 Timeout: mem_stall held 300 cycles -> mem_timeout_err=1 from wait count 255 and stays set after release; stall_count=300.
REQ-041 Saturation: force 70000 load-use cycles -> stall_count=16'hFFFF.
REQ-042 Reset mid-MEM_WAIT: assert rst asynchronously -> state=0, counters 0, err 0, with no clock edge required.
